// File: rtl/bfly_pair_buf_pkg.sv
// Shared types for the butterfly pair feeder: sample/block types and the fill/pair state.
package bfly_pair_buf_pkg;
   localparam int SIG       = 1;
   localparam int INT       = 3;
   localparam int FLT       = 6;
   localparam int WIDTH     = SIG + INT + FLT;
   localparam int LANES     = 16;
   localparam int DEPTH_DEF = 4;

   typedef logic signed [WIDTH-1:0] smp_t;
   typedef smp_t [LANES-1:0]        blk_t;

   typedef struct packed {
      smp_t re;
      smp_t im;
   } cplx_t;

   typedef cplx_t [LANES-1:0] cblk_t;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_PAIR = 1'b1
   } state_t;
endpackage

// File: rtl/bfly_pair_buf_if.sv
// Block-in / pair-out stream bundle between stage memory, the pair feeder and bfly_add.
interface bfly_pair_buf_if import bfly_pair_buf_pkg::*;;
   logic in_valid;
   logic in_ready;
   logic in_sof;
   blk_t in_re;
   blk_t in_im;
   logic out_valid;
   logic out_ready;
   logic out_last;
   blk_t din1_re;
   blk_t din1_im;
   blk_t din2_re;
   blk_t din2_im;
   logic err;

   modport master (
      output in_valid, in_sof, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_last, din1_re, din1_im, din2_re, din2_im, err
   );

   modport slave (
      input  in_valid, in_sof, in_re, in_im, out_ready,
      output in_ready, out_valid, out_last, din1_re, din1_im, din2_re, din2_im, err
   );
endinterface

// File: rtl/bfly_pair_buf_mem.sv
// Half-frame block store: one write port, one asynchronous read port, contents not reset.
module bfly_pair_buf_mem import bfly_pair_buf_pkg::*; #(
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  cblk_t         wdata,
   input  logic [AW-1:0] raddr,
   output cblk_t         rdata
);
   // Sized to the full address space so any counter value indexes a real entry.
   cblk_t mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/bfly_pair_buf.sv
// Pairs block k of the first half-frame with block DEPTH+k of the second and presents them registered.
module bfly_pair_buf import bfly_pair_buf_pkg::*; #(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   bfly_pair_buf_if.slave bus
);
   localparam int             CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH - 1);

   state_t         state_q, state_d, state_e;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_e;
   logic           out_valid_q, out_valid_d;
   logic           out_last_q, out_last_d;
   logic           err_q, err_d;
   cblk_t          din1_q, din1_d, din2_q, din2_d;
   cblk_t          in_blk, rd_blk;
   logic           acc, resync, mem_we;

   assign bus.in_ready = (state_q == ST_FILL) | ~out_valid_q | bus.out_ready;
   assign acc          = bus.in_valid & bus.in_ready;

   always_comb begin
      in_blk = '0;
      for (int i = 0; i < LANES; i++) begin
         in_blk[i].re = bus.in_re[i];
         in_blk[i].im = bus.in_im[i];
      end
   end

   bfly_pair_buf_mem #(.AW(CW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cnt_e),
      .wdata (in_blk),
      .raddr (cnt_q),
      .rdata (rd_blk)
   );

   // A misplaced sof restarts the frame: treat the block as fill slot 0.
   assign resync  = acc & bus.in_sof & ~((state_q == ST_FILL) & (cnt_q == '0));
   assign state_e = resync ? ST_FILL : state_q;
   assign cnt_e   = resync ? '0 : cnt_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q & ~bus.out_ready;
      out_last_d  = out_last_q;
      din1_d      = din1_q;
      din2_d      = din2_q;
      err_d       = err_q | resync;
      mem_we      = 1'b0;
      if (acc) begin
         cnt_d = (cnt_e == CNT_MAX) ? '0 : cnt_e + CW'(1);
         if (state_e == ST_FILL) begin
            mem_we  = 1'b1;
            state_d = (cnt_e == CNT_MAX) ? ST_PAIR : ST_FILL;
         end else begin
            din1_d      = rd_blk;
            din2_d      = in_blk;
            out_valid_d = 1'b1;
            out_last_d  = (cnt_e == CNT_MAX);
            state_d     = (cnt_e == CNT_MAX) ? ST_FILL : ST_PAIR;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FILL;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
         din1_q      <= '0;
         din2_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
         din1_q      <= din1_d;
         din2_q      <= din2_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_out
      assign bus.din1_re[i] = din1_q[i].re;
      assign bus.din1_im[i] = din1_q[i].im;
      assign bus.din2_re[i] = din2_q[i].re;
      assign bus.din2_im[i] = din2_q[i].im;
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.err       = err_q;
endmodule
